// File: rtl/pipe_seg_adder.sv
// Pipelined segmented ripple-carry adder/subtractor: SEG bits per stage, carry registered between stages.
// Optional saturation on signed overflow is enabled by defining PIPE_SEG_ADDER_SAT_EN (adds port sat_en).
module pipe_seg_adder #(
  parameter int WIDTH = 32,
  parameter int SEG   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             op_sub,
`ifdef PIPE_SEG_ADDER_SAT_EN
  input  logic             sat_en,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             ovf
);

  localparam int STAGES = WIDTH / SEG;

  if (WIDTH % SEG != 0) begin : g_bad_seg
    $error("pipe_seg_adder: WIDTH must be a multiple of SEG");
  end

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             carry;
    logic             sub;
    logic             sat;
    logic             ovf;
  } stage_t;

  stage_t            stage_q [STAGES];
  logic [STAGES-1:0] valid_v;
  logic [STAGES-1:0] load;
  logic              sat_in;

`ifdef PIPE_SEG_ADDER_SAT_EN
  assign sat_in = sat_en;
`else
  assign sat_in = 1'b0;
`endif

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    stage_t         up;
    stage_t         stg_d;
    stage_t         stg_q;
    logic [SEG:0]   seg_sum;
    logic [WIDTH-1:0] sum_new;

    // Stage 0 takes the raw beat; B is inverted here so later stages only ever add.
    if (k == 0) begin : g_src_in
      always_comb begin
        up       = '0;
        up.valid = in_valid;
        up.a_r   = a;
        up.b_r   = op_sub ? ~b : b;
        up.carry = op_sub | c_in;
        up.sub   = op_sub;
        up.sat   = sat_in;
      end
    end else begin : g_src_stage
      assign up = stage_q[k-1];
    end

    assign seg_sum = {1'b0, up.a_r[k*SEG +: SEG]} + {1'b0, up.b_r[k*SEG +: SEG]}
                   + {{SEG{1'b0}}, up.carry};

    always_comb begin
      sum_new                 = up.sum;
      sum_new[k*SEG +: SEG]   = seg_sum[SEG-1:0];
    end

    // load is asserted whenever this slot is empty or the slot downstream is taking its content.
    assign load[k]    = out_ready | ~(&valid_v[STAGES-1:k]);
    assign valid_v[k] = stg_q.valid;

    always_comb begin
      stg_d = stg_q;
      if (load[k]) begin
        stg_d = '0;
        if (up.valid) begin
          stg_d       = up;
          stg_d.sum   = sum_new;
          stg_d.carry = seg_sum[SEG];
          stg_d.ovf   = 1'b0;
          if (k == STAGES - 1) begin
            // a^b^s at the MSB recovers the carry into the MSB.
            stg_d.ovf = up.a_r[WIDTH-1] ^ up.b_r[WIDTH-1] ^ sum_new[WIDTH-1] ^ seg_sum[SEG];
            if (up.sat && stg_d.ovf) begin
              stg_d.sum = up.a_r[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                          : {1'b0, {(WIDTH-1){1'b1}}};
            end
          end
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        stg_q <= '0;
      end else begin
        stg_q <= stg_d;
      end
    end

    assign stage_q[k] = stg_q;
  end

  assign in_ready  = load[0];
  assign out_valid = stage_q[STAGES-1].valid;
  assign s         = stage_q[STAGES-1].sum;
  assign c_out     = stage_q[STAGES-1].carry;
  assign ovf       = stage_q[STAGES-1].ovf;

endmodule

// File: tb/tb_pipe_seg_adder.sv
// Self-checking bench for pipe_seg_adder (WIDTH=32, SEG=8): directed vector table, handshake sequences,
// and randomized traffic against an arithmetic reference model.
module tb_pipe_seg_adder;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, c_in, op_sub, out_valid, out_ready, c_out, ovf, sat_en;
  logic [W-1:0] a, b, s;

  always #5 clk = ~clk;

  pipe_seg_adder #(.WIDTH(32), .SEG(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c_in(c_in), .op_sub(op_sub),
`ifdef PIPE_SEG_ADDER_SAT_EN
    .sat_en(sat_en),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .s(s), .c_out(c_out), .ovf(ovf)
  );

  typedef struct { logic [31:0] s; logic c; logic v; } res_t;
  typedef struct {
    logic [31:0] a; logic [31:0] b; logic cin; logic sub; logic sat;
    logic [31:0] es; logic ec; logic ev;
  } vec_t;

  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  int   checks = 0;
  int   errors = 0;
  int   n_out  = 0;
  res_t exp_q[$];
  vec_t vecs[$];
  bit   stall_prev = 0;
  res_t held;

  function automatic res_t model(logic [31:0] ma, logic [31:0] mb, logic cin, logic sub, logic sat);
    res_t   r;
    logic [32:0] full;
    longint t;
    if (sub) full = {1'b0, ma} + {1'b0, ~mb} + 33'd1;
    else     full = {1'b0, ma} + {1'b0, mb} + {32'd0, cin};
    if (sub) t = longint'($signed(ma)) - longint'($signed(mb));
    else     t = longint'($signed(ma)) + longint'($signed(mb)) + longint'(cin);
    r.s = full[31:0];
    r.c = full[32];
    r.v = (t > SMAX) || (t < SMIN);
    if (sat && r.v) r.s = (t > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
    end
  endtask

  // One cycle starting at a negedge with inputs already driven; scores the handshakes of the coming edge.
  task automatic step(output bit acc);
    res_t e;
    #1;
    if (stall_prev) begin
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_s", s, held.s);
      chk("hold_c", {31'd0, c_out}, {31'd0, held.c});
      chk("hold_ovf", {31'd0, ovf}, {31'd0, held.v});
    end
    acc = in_valid && in_ready;
    if (acc) exp_q.push_back(model(a, b, c_in, op_sub, sat_en));
    if (out_valid && out_ready) begin
      n_out++;
      if (exp_q.size() == 0) begin
        chk("spurious_out", {31'd0, out_valid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("out_s", s, e.s);
        chk("out_c", {31'd0, c_out}, {31'd0, e.c});
        chk("out_ovf", {31'd0, ovf}, {31'd0, e.v});
      end
    end
    stall_prev = out_valid && !out_ready;
    held.s = s; held.c = c_out; held.v = ovf;
    @(negedge clk);
  endtask

  task automatic run_vec(vec_t v);
    int lat;
    bit got;
    a = v.a; b = v.b; c_in = v.cin; op_sub = v.sub; sat_en = v.sat;
    in_valid = 1'b1; out_ready = 1'b1;
    #1 chk("vec_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0; a = $urandom; b = $urandom; c_in = 1'b1; op_sub = 1'b0;
    lat = 1; got = 0;
    while (lat < 20 && !got) begin
      #1;
      if (out_valid) got = 1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
    chk("vec_timeout", {31'd0, got}, 32'd1);
    chk("vec_latency", lat, 4);
    chk("vec_s", s, v.es);
    chk("vec_c", {31'd0, c_out}, {31'd0, v.ec});
    chk("vec_ovf", {31'd0, ovf}, {31'd0, v.ev});
    @(negedge clk);
    #1 chk("vec_drained", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
  endtask

  task automatic add_vec(logic [31:0] va, logic [31:0] vb, logic cin, logic sub, logic sat,
                         logic [31:0] es, logic ec, logic ev);
    vec_t v;
    v.a = va; v.b = vb; v.cin = cin; v.sub = sub; v.sat = sat; v.es = es; v.ec = ec; v.ev = ev;
    vecs.push_back(v);
  endtask

  initial begin
    bit acc;
    int idx, cyc, start;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    c_in = 1'b0; op_sub = 1'b0; sat_en = 1'b0;

    add_vec(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
    add_vec(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    add_vec(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    add_vec(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0);
    add_vec(32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 1'b0, 32'h0000_0002, 1'b1, 1'b0);
    add_vec(32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 1'b0, 32'h0000_0002, 1'b1, 1'b0);
    add_vec(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
    add_vec(32'h00FF_FF00, 32'h0000_0100, 1'b0, 1'b0, 1'b0, 32'h0100_0000, 1'b0, 1'b0);
    add_vec(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1);
`ifdef PIPE_SEG_ADDER_SAT_EN
    add_vec(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1);
    add_vec(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 1'b1, 32'h8000_0000, 1'b1, 1'b1);
    add_vec(32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0, 1'b1, 32'h0000_0007, 1'b0, 1'b0);
`endif

    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_s", s, 32'd0);
    chk("rst_c", {31'd0, c_out}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Backpressure: fill with out_ready low, then release and stream the rest.
    out_ready = 1'b0; op_sub = 1'b0; c_in = 1'b0; sat_en = 1'b0; idx = 0;
    for (int c = 0; c < 8; c++) begin
      in_valid = 1'b1; a = idx; b = idx;
      step(acc);
      if (acc) idx++;
    end
    chk("bp_accepts", idx, 4);
    #1 chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1; cyc = 0; start = n_out;
    while ((idx < 10 || exp_q.size() > 0) && cyc < 40) begin
      in_valid = (idx < 10); a = idx; b = idx;
      step(acc);
      if (acc) idx++;
      cyc++;
    end
    in_valid = 1'b0;
    chk("bp_cycles", cyc, 10);
    chk("bp_outs", n_out - start, 10);

    // Reset with three beats in flight.
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = 32'h100 + i; b = 32'h3;
      step(acc);
    end
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_s", s, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    exp_q.delete(); stall_prev = 0;
    @(negedge clk);
    start = n_out;
    for (int i = 0; i < 8; i++) step(acc);
    chk("mid_rst_stale", n_out - start, 0);

    // Randomized traffic in phases of differing backpressure.
    for (int ph = 0; ph < 4; ph++) begin
      for (int i = 0; i < 600; i++) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 3) >= ph);
        case ($urandom_range(0, 5))
          0:       a = 32'hFFFF_FFFF;
          1:       a = 32'h7FFF_FFFF;
          2:       a = 32'h8000_0000;
          default: a = $urandom;
        endcase
        b = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2) : $urandom;
        c_in = $urandom_range(0, 1);
        op_sub = $urandom_range(0, 1);
`ifdef PIPE_SEG_ADDER_SAT_EN
        sat_en = $urandom_range(0, 1);
`endif
        step(acc);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) step(acc);
    chk("rand_drain", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
